// File: rtl/dmem_bus_arbiter.sv
// Data-memory bus arbiter: processor priority, starvation-forced secondary slot,
// and one-cycle read response routing back to the issuing master.
module dmem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  input  logic [DATA_WIDTH-1:0] p_wdata,
  output logic                  p_gnt,
  output logic                  p_stall,
  output logic                  p_rvalid,
  output logic [DATA_WIDTH-1:0] p_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_MemRead,
  output logic                  m_MemWrite,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          rd_p_q, rd_p_d;
  logic          rd_d_q, rd_d_d;
  logic          force_dma;

  assign force_dma = d_req && (starve_q == LIMIT);

  // Overlapping requests are expected, so priority (not unique) selection.
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      priority case (1'b1)
        force_dma: d_gnt = 1'b1;
        p_req:     p_gnt = 1'b1;
        d_req:     d_gnt = 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    m_addr     = '0;
    m_wdata    = '0;
    m_MemRead  = 1'b0;
    m_MemWrite = 1'b0;
    if (p_gnt) begin
      m_addr     = p_addr;
      m_wdata    = p_wdata;
      m_MemRead  = ~p_we;
      m_MemWrite = p_we;
    end else if (d_gnt) begin
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      m_MemRead  = ~d_we;
      m_MemWrite = d_we;
    end
  end

  always_comb begin
    starve_d = '0;
    if (d_req && !d_gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q
                                     : starve_q + CW'(1);
    end
    rd_p_d = p_gnt & ~p_we;
    rd_d_d = d_gnt & ~d_we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      rd_p_q   <= 1'b0;
      rd_d_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_p_q   <= rd_p_d;
      rd_d_q   <= rd_d_d;
    end
  end

  assign p_stall  = rst & p_req & ~p_gnt;
  assign p_rvalid = rst & rd_p_q;
  assign d_rvalid = rst & rd_d_q;
  assign p_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Randomized and directed bench for dmem_bus_arbiter against a
// rule-level reference model (denied-cycle count, pending read owners).
module tb_dmem_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, d_req, d_we;
  logic [AW-1:0] p_addr, d_addr;
  logic [DW-1:0] p_wdata, d_wdata, m_rdata;
  logic          p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] p_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          m_MemRead, m_MemWrite;

  int errors = 0;
  int checks = 0;
  int denied = 0;
  bit rvp = 0, rvd = 0;
  bit eg_p, eg_d;
  bit s_p_gnt, s_d_gnt, s_wr, s_rd;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_gnt(p_gnt), .p_stall(p_stall),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
    .m_rdata(m_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // One bus cycle: predict, check at negedge, advance model at posedge.
  task automatic cyc();
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    bit wr, rd;
    m_rdata = $urandom();
    eg_p = 0;
    eg_d = 0;
    if (rst) begin
      if (d_req && denied >= LIM) eg_d = 1;
      else if (p_req)             eg_p = 1;
      else if (d_req)             eg_d = 1;
    end
    ea = eg_p ? p_addr  : (eg_d ? d_addr  : '0);
    ew = eg_p ? p_wdata : (eg_d ? d_wdata : '0);
    wr = (eg_p && p_we) || (eg_d && d_we);
    rd = (eg_p && !p_we) || (eg_d && !d_we);
    @(negedge clk);
    s_p_gnt = p_gnt;
    s_d_gnt = d_gnt;
    s_wr    = m_MemWrite;
    s_rd    = m_MemRead;
    chk("p_gnt", p_gnt, eg_p);
    chk("d_gnt", d_gnt, eg_d);
    chk("p_stall", p_stall, rst && p_req && !eg_p);
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ew);
    chk("m_MemRead", m_MemRead, rd);
    chk("m_MemWrite", m_MemWrite, wr);
    chk("p_rvalid", p_rvalid, rst && rvp);
    chk("d_rvalid", d_rvalid, rst && rvd);
    if (rst && rvp) chk("p_rdata", p_rdata, m_rdata);
    if (rst && rvd) chk("d_rdata", d_rdata, m_rdata);
    @(posedge clk);
    rvp = rst && eg_p && !p_we;
    rvd = rst && eg_d && !d_we;
    if (!rst)                 denied = 0;
    else if (d_req && !eg_d)  denied = (denied < LIM) ? denied + 1 : LIM;
    else                      denied = 0;
    #1;
  endtask

  task automatic idle();
    p_req = 0;
    d_req = 0;
    cyc();
  endtask

  bit pend_p = 0, pend_d = 0;

  initial begin
    rst = 0; p_req = 1; d_req = 1; p_we = 0; d_we = 0;
    p_addr = 32'h100; d_addr = 32'h200;
    p_wdata = '0; d_wdata = '0; m_rdata = '0;
    cyc();
    cyc();
    chk("t1_no_gnt", {s_p_gnt, s_d_gnt, s_rd, s_wr}, 4'b0);
    rst = 1;
    idle();

    p_req = 1; p_we = 0; p_addr = 32'h0000_2000;
    cyc();
    chk("t2_gnt", s_p_gnt, 1'b1);
    chk("t2_rd", s_rd, 1'b1);
    idle();

    p_req = 1; d_req = 1; p_we = 0; d_we = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("t3_dgnt", s_d_gnt, (i % 5) == 4);
      chk("t3_pgnt", s_p_gnt, (i % 5) != 4);
    end
    idle();

    d_req = 1; d_we = 1; d_addr = 32'h0000_7f04;
    d_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("t4_wr", {s_d_gnt, s_wr, s_rd}, 3'b110);
    idle();
    idle();

    p_req = 1; d_req = 1; p_we = 0; d_we = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("t5_forced", s_d_gnt, 1'b1);
    d_req = 0;
    cyc();
    chk("t5_p_after", s_p_gnt, 1'b1);
    idle();
    idle();

    p_req = 1; d_req = 1;
    for (int i = 0; i < 3; i++) cyc();
    d_req = 0;
    cyc();
    d_req = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_dgnt", s_d_gnt, i == 4);
    end
    idle();

    for (int n = 0; n < 600; n++) begin
      if (s_p_gnt || ($urandom_range(15) == 0)) pend_p = 0;
      if (s_d_gnt || ($urandom_range(15) == 0)) pend_d = 0;
      if (!pend_p && $urandom_range(1) == 1) begin
        pend_p  = 1;
        p_we    = $urandom_range(1) == 1;
        p_addr  = $urandom();
        p_wdata = $urandom();
      end
      if (!pend_d && $urandom_range(2) != 0) begin
        pend_d  = 1;
        d_we    = $urandom_range(1) == 1;
        d_addr  = $urandom();
        d_wdata = $urandom();
      end
      p_req = pend_p;
      d_req = pend_d;
      rst   = ($urandom_range(49) != 0);
      cyc();
    end
    rst = 1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
